bram_stream_reader: RTL

Read-side controller placed directly downstream of the block RAM. On a start pulse it walks an inclusive address range, drives the BRAM read port (`ram_enable`, `write_enable`, `address`) and absorbs the RAM's one-cycle read latency in a 2-entry output FIFO. It presents the words as a valid/ready stream with a last-beat flag. It is the standard way for downstream compute stages to pull buffered data out of BRAM.

---
 rtl/bram_stream_reader.sv | 135 +++++++++++++
 1 files changed

// File: rtl/bram_stream_reader.sv
// Streams an inclusive BRAM address range out as a valid/ready stream,
// hiding the RAM's one-cycle read latency behind a 2-entry FIFO.
module bram_stream_reader #(
    parameter int RAM_WIDTH     = 32,
    parameter int RAM_ADDR_BITS = 9
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     start,
    input  logic [RAM_ADDR_BITS-1:0] start_addr,
    input  logic [RAM_ADDR_BITS-1:0] end_addr,
    output logic                     busy,
    output logic                     done,
    output logic                     ram_enable,
    output logic                     write_enable,
    output logic [RAM_ADDR_BITS-1:0] address,
    input  logic [RAM_WIDTH-1:0]     ram_data,
    output logic [RAM_WIDTH-1:0]     out_data,
    output logic                     out_valid,
    output logic                     out_last,
    input  logic                     out_ready
);

    localparam logic [RAM_ADDR_BITS-1:0] ADDR_ONE = {{(RAM_ADDR_BITS-1){1'b0}}, 1'b1};
    localparam logic [RAM_ADDR_BITS:0]   WORD_ONE = {{RAM_ADDR_BITS{1'b0}}, 1'b1};

    typedef enum logic [1:0] {IDLE, READ, DRAIN, FINISH} state_t;

    state_t                   state;
    logic [RAM_ADDR_BITS-1:0] addr_cnt;
    logic [RAM_ADDR_BITS:0]   words_left;
    logic [RAM_ADDR_BITS-1:0] span;

    // Read issued last cycle: ram_data is valid now and lands in the FIFO at this edge.
    logic                     vld_p1;
    logic                     last_p1;

    logic [RAM_WIDTH-1:0]     fifo_data [2];
    logic [1:0]               fifo_last;
    logic                     rd_ptr;
    logic                     wr_ptr;
    logic [1:0]               fifo_count;

    logic                     pop;
    logic                     push;
    logic                     issue;
    logic [1:0]               occupancy;

    assign span         = end_addr - start_addr;
    assign out_valid    = (fifo_count != 2'd0);
    assign out_data     = fifo_data[rd_ptr];
    assign out_last     = out_valid && fifo_last[rd_ptr];
    assign pop          = out_valid && out_ready;
    assign push         = vld_p1;

    // Occupancy after this cycle's pop; a new read is only issued if a FIFO slot is guaranteed.
    assign occupancy    = fifo_count + {1'b0, vld_p1} - {1'b0, pop};
    assign issue        = (state == READ) && (occupancy < 2'd2);

    assign ram_enable   = issue;
    assign write_enable = 1'b0;
    assign address      = addr_cnt;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            addr_cnt   <= '0;
            words_left <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            vld_p1     <= 1'b0;
            last_p1    <= 1'b0;
        end else begin
            done    <= 1'b0;
            vld_p1  <= issue;
            last_p1 <= issue && (words_left == WORD_ONE);
            if (issue) begin
                addr_cnt   <= addr_cnt + ADDR_ONE;
                words_left <= words_left - WORD_ONE;
            end
            case (state)
                IDLE: begin
                    if (start) begin
                        addr_cnt   <= start_addr;
                        words_left <= {1'b0, span} + WORD_ONE;
                        busy       <= 1'b1;
                        state      <= READ;
                    end
                end
                READ: begin
                    if (issue && (words_left == WORD_ONE)) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    // The tagged beat is the final read, so its handshake leaves nothing behind.
                    if (pop && out_last) begin
                        done  <= 1'b1;
                        state <= FINISH;
                    end
                end
                FINISH: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            fifo_data[0] <= '0;
            fifo_data[1] <= '0;
            fifo_last    <= 2'b00;
            rd_ptr       <= 1'b0;
            wr_ptr       <= 1'b0;
            fifo_count   <= 2'd0;
        end else begin
            if (push) begin
                fifo_data[wr_ptr] <= ram_data;
                fifo_last[wr_ptr] <= last_p1;
                wr_ptr            <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 2'd1;
                2'b01:   fifo_count <= fifo_count - 2'd1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

endmodule
